galaksija_uart_tx: RTL
======================

Name: galaksija_uart_tx

Overview:
- Serial transmitter: the output end of the serial console link. The keyboard path receives; this block sends.
- The CPU writes bytes through a memory-mapped strobe. The block buffers them in a small FIFO and shifts them out as 8N1 frames (optionally 8E1) on ser_tx.
- Uses the same `cfg_divider` convention as the serial keyboard receiver, so one baud constant (`f_clk/baud`) configures both ends.
- Sits in the `clk` domain beside the CPU; the decode logic in the top module drives `wr` when the CPU stores to the TX address.

Parameters:
- FIFO_AW, 4, log2 of FIFO depth (depth = 16 bytes).
- STOP_BITS, 1, number of stop bits, 1 or 2; any other value behaves as 1.

Ports:
- clk  in  1  system clock (25 MHz)
- reset_n  in  1  synchronous active-low reset
- cfg_divider  in  32  clocks per bit; values 0 and 1 behave as 1
- wr  in  1  write strobe, one byte per asserted cycle
- data  in  8  byte to send, sampled when wr=1
- full  out  1  FIFO full; a write in this cycle is dropped
- overflow  out  1  one-cycle pulse when a write is dropped
- busy  out  1  frame in progress or FIFO non-empty
- ser_tx  out  1  serial line, idle high

Behaviour:
- Reset is synchronous: reset_n=0 sampled at a rising edge of clk.
  - ser_tx=1, full=0, overflow=0, busy=0.
  - FIFO emptied, state IDLE, bit counter and baud counter cleared.
  - Reset mid-frame aborts the frame immediately; ser_tx is high from the next cycle.
- FIFO:
  - Synchronous, registered count, 2^FIFO_AW entries.
  - full = (count == depth), registered.
  - A write is accepted iff wr=1 and full=0 in the same cycle.
  - A write with full=1 is dropped, and overflow pulses high for 1 cycle.
  - Simultaneous push and pop are allowed; count is unchanged.
  - A pop in the same cycle does not make room for a write that sees full=1.
  - Pointers wrap modulo depth.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
  - IDLE: when the FIFO is non-empty, pop the head into a shift register, ser_tx<=0, baud counter loaded, go to START.
  - Each bit lasts exactly max(cfg_divider,1) clocks. The baud counter counts down and the bit advances when it reaches 0.
  - START → DATA: sends 8 bits LSB first, with a bit index 0..7.
  - DATA → STOP (or → PARITY, then STOP).
  - STOP: ser_tx=1 for STOP_BITS bit times, then back to IDLE.
  - If the FIFO is non-empty at the end of STOP, the next START follows with no extra idle bit; back-to-back frames have zero gap.
- Latency: a write accepted at edge N with the FSM in IDLE causes the pop at edge N+1. ser_tx is low from edge N+1.
- busy = (state != IDLE) || (count != 0).
- cfg_divider is sampled at every bit boundary. A change mid-bit takes effect from the next bit.
- Frame length = (1 + 8 + STOP_BITS) × max(cfg_divider,1) clocks, plus one divider period when parity is enabled.

Optional Feature:
- Macro: UART_TX_PARITY_EN
- Defined: a PARITY state is inserted after DATA. It transmits even parity, the XOR of the 8 data bits, for one bit time. The frame is 8E1 (or 8E2).
- Undefined: no PARITY state and no parity logic; the frame is 8N1 (or 8N2).

Decomposition:
- Package galaksija_uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constant DATA_BITS=8;
  - a function for the effective divider, max(d,1).
- The receiver shares this package.
- One sub-module, galaksija_tx_fifo: a parameterised synchronous FIFO with push, pop, dout, count and full/empty.
- The FSM and baud counter stay in the top of the block.

Test Plan:
- cfg_divider=217, write 0x41 once while idle:
  - ser_tx low for 217 clk, then bits 1,0,0,0,0,0,1,0 at 217 clk each, then high;
  - busy deasserts 2170 clk after the start edge.
- Write 0x55, 0xAA on consecutive cycles:
  - two frames with no idle gap between them;
  - ser_tx alternates every bit through the data field.
- Write 0x00 and wait for busy; then write 17 bytes back to back:
  - full asserts after the 16th accepted write;
  - the 17th is dropped with a 1-cycle overflow pulse;
  - exactly 17 frames are sent (0x00 plus 16).
- Pull reset_n low in the middle of the DATA bit 3 period for 1 cycle:
  - ser_tx=1 from the next cycle;
  - busy=0, full=0;
  - no further frames are sent.
- Set cfg_divider=0, write 0xFF: every bit lasts 1 clk, and the frame is 10 clk long.
- Loopback ser_tx to the serial keyboard receiver with cfg_divider=f_clk/115200, sending 0x00..0xFF:
  - every byte is received identically, in order;
  - with UART_TX_PARITY_EN, the parity bit for 0x07 is 1.

Source files
------------

// File: rtl/galaksija_uart_pkg.sv
// Shared definitions for the Galaksija serial console link (transmitter and receiver).
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   uart_state_t  - frame FSM states (IDLE, START, DATA, PARITY, STOP)
//   DATA_BITS     - data bits per frame
//   eff_divider() - clocks per bit actually used for a cfg_divider value
package galaksija_uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // A divider of 0 would mean a zero-length bit; treat it like 1.
  function automatic logic [31:0] eff_divider(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/galaksija_uart_tx_if.sv
// CPU-side write port of the serial transmitter.
// Latency: n/a (wires only).
// Backpressure: writer watches full; a write while full is dropped and flagged on overflow.
//
// Signals:
//   wr       - write strobe, one byte per asserted cycle (master -> slave)
//   data     - byte to send, sampled when wr=1     (master -> slave)
//   full     - FIFO full, a write now is dropped   (slave -> master)
//   overflow - one-cycle pulse after a dropped write (slave -> master)
//   busy     - frame in progress or bytes queued   (slave -> master)
interface galaksija_uart_tx_if;
  import galaksija_uart_pkg::*;

  logic                 wr;
  logic [DATA_BITS-1:0] data;
  logic                 full;
  logic                 overflow;
  logic                 busy;

  modport master (output wr, data, input full, overflow, busy);
  modport slave  (input wr, data, output full, overflow, busy);

endinterface

// File: rtl/galaksija_tx_fifo.sv
// Synchronous FIFO holding bytes waiting to be serialised.
// Latency: a push at edge N is visible on dout/count/empty after edge N; dout is a direct read of the head.
// Backpressure: push ignored while full (registered); a simultaneous pop never frees room for that push.
//
// Ports:
//   clk, reset_n    - clock, synchronous active-low reset (empties the FIFO)
//   push, din       - write request and data
//   pop             - remove head (ignored when empty)
//   dout            - current head entry
//   count           - occupancy, 0..2**AW
//   full, empty     - full is registered, empty derives from the registered count
module galaksija_tx_fifo
  import galaksija_uart_pkg::*;
#(
  parameter int AW = 4,
  parameter int W  = DATA_BITS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          full_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == CNT_MAX);
    end
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = count_q;
  assign full  = full_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/galaksija_uart_tx.sv
// Serial console transmitter: queues CPU bytes and shifts them out as 8N1/8N2 frames (8E1/8E2 with UART_TX_PARITY_EN).
// Latency: write accepted at edge N while idle -> pop and start bit on ser_tx from edge N+1; back-to-back frames have no gap.
// Backpressure: 16-deep queue; writes while full are dropped and reported by a one-cycle overflow pulse.
//
// Ports:
//   clk, reset_n  - clock, synchronous active-low reset (aborts any frame, ser_tx high next cycle)
//   cfg_divider   - clocks per bit, 0 and 1 both mean 1; sampled at every bit boundary
//   bus (slave)   - wr/data in, full/overflow/busy out
//   ser_tx        - serial line, idle high
// Build option: define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module galaksija_uart_tx
  import galaksija_uart_pkg::*;
#(
  parameter int FIFO_AW   = 4,
  parameter int STOP_BITS = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         cfg_divider,
  galaksija_uart_tx_if.slave  bus,
  output logic                ser_tx
);

  // Anything other than 2 stop bits falls back to 1.
  localparam int         STOPS     = (STOP_BITS == 2) ? 2 : 1;
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOPS - 1);

  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_dout;
  logic [FIFO_AW:0]     fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;

  galaksija_tx_fifo #(
    .AW (FIFO_AW),
    .W  (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (bus.wr),
    .din     (bus.data),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  uart_state_t          state_q, state_d;
  logic [31:0]          baud_q, baud_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tx_q, tx_d;
  logic                 ovf_q;
  logic                 load_frame;
  logic                 baud_tick;
  logic [31:0]          bit_len_m1;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  // The baud counter is reloaded with (bit length - 1) at each bit boundary,
  // so a bit lasts exactly eff_divider(cfg_divider) clocks and a divider
  // change only affects bits that start after it.
  assign baud_tick  = (baud_q == 32'd0);
  assign bit_len_m1 = eff_divider(cfg_divider) - 32'd1;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    load_frame = 1'b0;
    fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif

    if (state_q != IDLE && !baud_tick) begin
      baud_d = baud_q - 32'd1;
    end

    case (state_q)
      IDLE: begin
        load_frame = !fifo_empty;
      end
      START: begin
        if (baud_tick) begin
          tx_d    = shreg_q[0];
          idx_d   = '0;
          baud_d  = bit_len_m1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          baud_d = bit_len_m1;
          if (idx_q == LAST_DATA) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            // shreg_q[0] is the bit on the line now; [1] goes out next.
            idx_d   = idx_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          idx_d   = '0;
          baud_d  = bit_len_m1;
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          if (idx_q == LAST_STOP) begin
            // Chain straight into the next start bit when more data waits.
            if (!fifo_empty) begin
              load_frame = 1'b1;
            end else begin
              tx_d    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            idx_d  = idx_q + 3'd1;
            baud_d = bit_len_m1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    if (load_frame) begin
      fifo_pop = 1'b1;
      shreg_d  = fifo_dout;
      tx_d     = 1'b0;
      baud_d   = bit_len_m1;
      state_d  = START;
`ifdef UART_TX_PARITY_EN
      par_d    = ^fifo_dout;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      // Registered so the CPU sees a clean pulse the cycle after the drop.
      ovf_q   <= bus.wr && fifo_full;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.full     = fifo_full;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q != IDLE) || (fifo_count != '0);
  assign ser_tx       = tx_q;

endmodule
